// File: rtl/out_shift_reg.sv
// Output serializer bank: N2 lanes of N1-bit registers, word-loaded through a chain, shifted out bit-serially.
// Optional OUT_SHIFT_REG_LSB_FIRST_EN reverses serial direction (LSB leaves first).
module out_shift_reg #(
  parameter int N1 = 90,
  parameter int N2 = 6
) (
  input  logic          Clock,
  input  logic          nReset,
  input  logic          SelShift,
  input  logic          SelKeep,
  input  logic [N1-1:0] In,
  output logic [N2-1:0] Out
);

  logic [N1-1:0] laneReg [N2];

  // nReset is active-high despite its name; hold (SelKeep) outranks shift/load.
  always_ff @(posedge Clock) begin
    if (nReset) begin
      for (int unsigned j = 0; j < N2; j++) laneReg[j] <= '0;
    end else if (!SelKeep) begin
      if (SelShift) begin
        for (int unsigned j = 0; j < N2; j++) begin
`ifdef OUT_SHIFT_REG_LSB_FIRST_EN
          laneReg[j] <= {1'b0, laneReg[j][N1-1:1]};
`else
          laneReg[j] <= {laneReg[j][N1-2:0], 1'b0};
`endif
        end
      end else begin
        laneReg[0] <= In;
        for (int unsigned j = 1; j < N2; j++) laneReg[j] <= laneReg[j-1];
      end
    end
  end

  always_comb begin
    Out = '0;
    for (int unsigned j = 0; j < N2; j++) begin
`ifdef OUT_SHIFT_REG_LSB_FIRST_EN
      Out[j] = laneReg[j][0];
`else
      Out[j] = laneReg[j][N1-1];
`endif
    end
  end

endmodule

// File: tb/tb_out_shift_reg.sv
// Self-checking bench for out_shift_reg: directed scenarios plus randomized modes against a word/bit-count model.
module tb_out_shift_reg;
  localparam int N1 = 90;
  localparam int N2 = 6;

  logic          Clock = 1'b0;
  logic          nReset = 1'b1;
  logic          SelShift = 1'b0;
  logic          SelKeep = 1'b1;
  logic [N1-1:0] In = '0;
  logic [N2-1:0] Out;

  out_shift_reg #(.N1(N1), .N2(N2)) dut (
    .Clock(Clock), .nReset(nReset), .SelShift(SelShift),
    .SelKeep(SelKeep), .In(In), .Out(Out)
  );

  always #5 Clock = ~Clock;

  // Model: each lane holds the word it was loaded with and how many bits have left it.
  logic [N1-1:0] mWord [N2];
  int            mCnt  [N2];
  int errCount = 0;
  int checkCount = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [N1-1:0] randWord();
    logic [95:0] w;
    w = {$urandom, $urandom, $urandom};
    return w[N1-1:0];
  endfunction

  function automatic logic [N2-1:0] expOut();
    logic [N2-1:0] e;
    e = '0;
    for (int j = 0; j < N2; j++) begin
      if (mCnt[j] < N1) begin
`ifdef OUT_SHIFT_REG_LSB_FIRST_EN
        e[j] = mWord[j][mCnt[j]];
`else
        e[j] = mWord[j][N1-1-mCnt[j]];
`endif
      end
    end
    return e;
  endfunction

  task automatic modelEdge();
    if (nReset) begin
      for (int j = 0; j < N2; j++) begin mWord[j] = '0; mCnt[j] = 0; end
    end else if (!SelKeep) begin
      if (SelShift) begin
        for (int j = 0; j < N2; j++) if (mCnt[j] < N1) mCnt[j]++;
      end else begin
        for (int j = N2 - 1; j > 0; j--) begin mWord[j] = mWord[j-1]; mCnt[j] = mCnt[j-1]; end
        mWord[0] = In;
        mCnt[0] = 0;
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge Clock);
    modelEdge();
    #1;
    check(tag, 128'(Out), 128'(expOut()));
  endtask

  task automatic drive(input logic rst, input logic keep, input logic shift, input logic [N1-1:0] din);
    nReset = rst; SelKeep = keep; SelShift = shift; In = din;
  endtask

  logic [N1-1:0] words [N2];
  logic [N1-1:0] cap   [N2];
  logic [N1-1:0] ones;
  logic [7:0]    lsbSeq;

  initial begin
    ones = '1;
    for (int j = 0; j < N2; j++) begin mWord[j] = '0; mCnt[j] = 0; end
    words[0] = N1'(29389123); words[1] = ones; words[2] = N1'(231);
    words[3] = N1'(281267);   words[4] = ones; words[5] = N1'(6432);

    // Arbitrary prior contents, then reset for two edges.
    repeat (2) tick("init_reset");
    for (int i = 0; i < N2; i++) begin drive(0, 0, 0, randWord()); tick("prior_load"); end
    drive(0, 0, 1, randWord()); tick("prior_shift");
    drive(1, 0, 0, randWord());
    repeat (2) tick("reset");
    check("reset_zero", 128'(Out), 128'(0));
    drive(0, 1, 0, randWord());
    repeat (3) tick("release_keep");
    check("release_zero", 128'(Out), 128'(0));

    // Directed word load.
    for (int i = 0; i < N2; i++) begin drive(0, 0, 0, words[i]); tick("load"); end
`ifndef OUT_SHIFT_REG_LSB_FIRST_EN
    check("load_out", 128'(Out), 128'(6'b010010));
`endif

    // Hold with both SelShift values; In changes ignored.
    for (int i = 0; i < 40; i++) begin
      drive(0, 1, (i >= 20), randWord());
      tick("hold");
    end

    // Serial unload: capture each lane before every edge.
    for (int i = 0; i < N1; i++) begin
      drive(0, 0, 1, randWord());
      for (int j = 0; j < N2; j++) begin
`ifdef OUT_SHIFT_REG_LSB_FIRST_EN
        cap[j][i] = Out[j];
`else
        cap[j][N1-1-i] = Out[j];
`endif
      end
      tick("unload");
    end
    for (int j = 0; j < N2; j++) check($sformatf("capture_lane%0d", j), 128'(cap[j]), 128'(words[N2-1-j]));
    for (int i = 0; i < 5; i++) begin tick("overshift"); check("overshift_zero", 128'(Out), 128'(0)); end

    // Reset mid-shift, then reload.
    for (int i = 0; i < N2; i++) begin drive(0, 0, 0, randWord()); tick("reload1"); end
    drive(0, 0, 1, '0);
    repeat (45) tick("midshift");
    drive(1, 0, 1, randWord()); tick("mid_reset");
    check("mid_reset_zero", 128'(Out), 128'(0));
    for (int i = 0; i < N2; i++) begin drive(0, 0, 0, ones); tick("reload2"); end
    check("reload_ones", 128'(Out), 128'({N2{1'b1}}));

`ifdef OUT_SHIFT_REG_LSB_FIRST_EN
    drive(1, 0, 0, '0); tick("lsb_reset");
    drive(0, 0, 0, N1'(231)); tick("lsb_load");
    lsbSeq = 8'b1110_0111;
    drive(0, 0, 1, '0);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("lsb_bit%0d", i), 128'(Out[0]), 128'((i < 8) ? lsbSeq[i] : 1'b0));
      tick("lsb_shift");
    end
`endif

    // Randomized modes, with rare resets.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), randWord());
      tick("random");
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
